cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between NUM_SRC result producers (ALU, load/store unit, ...).

---
 rtl/cdb_arbiter_pkg.sv | 24 ++
 rtl/cdb_arbiter_rr_picker.sv | 33 +++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and index helpers for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned DEF_NUM_SRC = 2;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TAG_W   = 32;

  // Rob tag value meaning "no dependency"; such results are never broadcast.
  localparam int unsigned NO_TAG = 0;

  // (a + b) modulo n, valid for a, b < n.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

  // (idx + 1) modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return wrap_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  // Scan N positions starting at the pointer; the first occupied one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_cand = IW'(wrap_add(32'(i_ptr), off, N));
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold slot per producer, round-robin grant,
// one registered broadcast beat per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  parameter  int unsigned TAG_W   = DEF_TAG_W,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC),
  localparam int unsigned CNT_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    req_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   req_data,
  output logic [NUM_SRC-1:0]          req_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SRC_W-1:0]            cdb_src,
  output logic [CNT_W-1:0]            pending
);

  logic [NUM_SRC-1:0] r_hv;
  logic [TAG_W-1:0]   r_ht [NUM_SRC];
  logic [DATA_W-1:0]  r_hd [NUM_SRC];
  logic [SRC_W-1:0]   r_rr_ptr;

  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [SRC_W-1:0]   r_cdb_src;

  logic [TAG_W-1:0]   w_req_tag  [NUM_SRC];
  logic [DATA_W-1:0]  w_req_data [NUM_SRC];
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_xfer;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic [CNT_W-1:0]   w_pending;

  // Split the flat request buses into per-source fields.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_req_tag[i]  = req_tag[i*TAG_W +: TAG_W];
      w_req_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  cdb_arbiter_rr_picker #(
    .N (NUM_SRC)
  ) u_picker (
    .i_req   (r_hv),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any)
  );

  // A slot accepts when empty or draining this cycle; never during reset or flush.
  assign req_ready = (rst || flush) ? '0 : (~r_hv | w_grant);
  assign w_xfer    = req_valid & req_ready;

  // Hold slots: refill on transfer (tag zero leaves the slot empty), clear on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hv <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        r_ht[i] <= '0;
        r_hd[i] <= '0;
      end
    end else if (flush) begin
      r_hv <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_xfer[i]) begin
          r_hv[i] <= (w_req_tag[i] != TAG_W'(NO_TAG));
          r_ht[i] <= w_req_tag[i];
          r_hd[i] <= w_req_data[i];
        end else if (w_grant[i]) begin
          r_hv[i] <= 1'b0;
        end
      end
    end
  end

  // Broadcast register and round-robin pointer; idle edges keep the last beat's fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_tag  <= r_ht[w_gnt_idx];
        r_cdb_data <= r_hd[w_gnt_idx];
        r_cdb_src  <= w_gnt_idx;
        r_rr_ptr   <= SRC_W'(wrap_inc(32'(w_gnt_idx), NUM_SRC));
      end
    end
  end

  // Occupied slot count.
  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_hv[i]) w_pending = w_pending + CNT_W'(1);
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;
  assign pending   = w_pending;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid;
  logic [63:0] req_tag;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        cdb_valid;
  logic [31:0] cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_src;
  logic [1:0]  pending;

  int n_checks;
  int n_errors;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] t0, d0, t1, d1;
    logic [1:0]  rdy;
    logic        cv;
    logic [31:0] tag, data;
    logic        src;
    logic [1:0]  pend;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check ready before the
  // rising edge, then advance to just after the rising edge.
  task automatic step(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] d0,
                      input logic [31:0] t1, input logic [31:0] d1, input logic fl,
                      input logic [1:0] erdy, input string nm);
    @(negedge clk);
    req_valid = v;
    req_tag   = {t1, t0};
    req_data  = {d1, d0};
    flush     = fl;
    #1;
    chk({nm, ".ready"}, 32'(req_ready), 32'(erdy));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input logic ev, input logic [31:0] et, input logic [31:0] ed,
                         input logic es, input logic [1:0] ep, input string nm);
    chk({nm, ".valid"},   32'(cdb_valid), 32'(ev));
    chk({nm, ".tag"},     cdb_tag, et);
    chk({nm, ".data"},    cdb_data, ed);
    chk({nm, ".src"},     32'(cdb_src), 32'(es));
    chk({nm, ".pending"}, 32'(pending), 32'(ep));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;

    // Reset state while rst is held.
    @(posedge clk);
    #1;
    chk("reset.ready", 32'(req_ready), 32'h0);
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // v, t0, d0, t1, d1, rdy, cv, tag, data, src, pend
    // Contention from rr_ptr=0: tag 3 then tag 4.
    vq.push_back('{2'b11, 32'h3, 32'h33, 32'h4, 32'h44, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, 2'd2});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1, 32'h3, 32'h33, 1'b0, 2'd1});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h4, 32'h44, 1'b1, 2'd0});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h4, 32'h44, 1'b1, 2'd0});
    // Single ALU result, two-edge latency.
    vq.push_back('{2'b01, 32'h5, 32'hDEADBEEF, 32'h0, 32'h0, 2'b11, 1'b0, 32'h4, 32'h44, 1'b1, 2'd1});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h5, 32'hDEADBEEF, 1'b0, 2'd0});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h5, 32'hDEADBEEF, 1'b0, 2'd0});
    // Tag zero: accepted, never broadcast.
    vq.push_back('{2'b01, 32'h0, 32'h1234, 32'h0, 32'h0, 2'b11, 1'b0, 32'h5, 32'hDEADBEEF, 1'b0, 2'd0});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h5, 32'hDEADBEEF, 1'b0, 2'd0});
    // Single LSB result (rr_ptr=1), returns rr_ptr to 0.
    vq.push_back('{2'b10, 32'h0, 32'h0, 32'h9, 32'h99, 2'b11, 1'b0, 32'h5, 32'hDEADBEEF, 1'b0, 2'd1});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h9, 32'h99, 1'b1, 2'd0});
    // Full-slot backpressure on LSB holding tag 7.
    vq.push_back('{2'b11, 32'h30, 32'h3030, 32'h7, 32'h77, 2'b11, 1'b0, 32'h9, 32'h99, 1'b1, 2'd2});
    vq.push_back('{2'b11, 32'h31, 32'h3131, 32'h8, 32'h88, 2'b01, 1'b1, 32'h30, 32'h3030, 1'b0, 2'd2});
    vq.push_back('{2'b10, 32'h0, 32'h0, 32'h8, 32'h88, 2'b10, 1'b1, 32'h7, 32'h77, 1'b1, 2'd2});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1, 32'h31, 32'h3131, 1'b0, 2'd1});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 32'h8, 32'h88, 1'b1, 2'd0});
    vq.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h8, 32'h88, 1'b1, 2'd0});

    for (int i = 0; i < vq.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(vq[i].v, vq[i].t0, vq[i].d0, vq[i].t1, vq[i].d1, 1'b0, vq[i].rdy, nm);
      chk_out(vq[i].cv, vq[i].tag, vq[i].data, vq[i].src, vq[i].pend, nm);
    end

    // Fairness: both producers stream fresh tags for 9 cycles, then drain.
    begin
      int a;
      int b;
      logic [1:0] erdy;
      logic [31:0] etag;
      logic [1:0] acc;
      a = 0;
      b = 0;
      for (int c = 0; c < 9; c++) begin
        string nm;
        nm = $sformatf("fair%0d", c);
        if (c == 0)      erdy = 2'b11;
        else if (c % 2)  erdy = 2'b01;
        else             erdy = 2'b10;
        @(negedge clk);
        req_valid = 2'b11;
        req_tag   = {32'h20 + 32'(b), 32'h10 + 32'(a)};
        req_data  = {32'hA000_0020 + 32'(b), 32'hA000_0010 + 32'(a)};
        flush     = 1'b0;
        #1;
        chk({nm, ".ready"}, 32'(req_ready), 32'(erdy));
        acc = req_ready;
        @(posedge clk);
        #1;
        if (acc[0]) a++;
        if (acc[1]) b++;
        if (c == 0) begin
          chk({nm, ".valid"},   32'(cdb_valid), 32'h0);
          chk({nm, ".pending"}, 32'(pending), 32'd2);
        end else begin
          etag = (c % 2) ? 32'h10 + 32'((c - 1) / 2) : 32'h20 + 32'((c - 2) / 2);
          chk_out(1'b1, etag, 32'hA000_0000 + etag, (c % 2) ? 1'b0 : 1'b1, 2'd2, nm);
        end
      end
      step(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, "fair_drain0");
      chk_out(1'b1, 32'h14, 32'hA000_0014, 1'b0, 2'd1, "fair_drain0");
      step(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, "fair_drain1");
      chk_out(1'b1, 32'h24, 32'hA000_0024, 1'b1, 2'd0, "fair_drain1");
    end

    // Flush with both slots full and rr_ptr=1; new requests during flush are refused.
    step(2'b01, 32'h40, 32'h400, 0, 0, 1'b0, 2'b11, "fl0");
    chk_out(1'b0, 32'h24, 32'hA000_0024, 1'b1, 2'd1, "fl0");
    step(2'b11, 32'h42, 32'h420, 32'h41, 32'h410, 1'b0, 2'b11, "fl1");
    chk_out(1'b1, 32'h40, 32'h400, 1'b0, 2'd2, "fl1");
    step(2'b11, 32'h44, 32'h440, 32'h45, 32'h450, 1'b1, 2'b00, "fl2");
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, "fl2");
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, "fl3");
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, "fl3");
    // rr_ptr back at 0: ALU wins first.
    step(2'b11, 32'h50, 32'h500, 32'h51, 32'h510, 1'b0, 2'b11, "fl4");
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd2, "fl4");
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, "fl5");
    chk_out(1'b1, 32'h50, 32'h500, 1'b0, 2'd1, "fl5");
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, "fl6");
    chk_out(1'b1, 32'h51, 32'h510, 1'b1, 2'd0, "fl6");

    // Asynchronous reset in the middle of a broadcast cycle.
    step(2'b01, 32'h60, 32'h600, 0, 0, 1'b0, 2'b11, "rs0");
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, "rs1");
    chk_out(1'b1, 32'h60, 32'h600, 1'b0, 2'd0, "rs1");
    step(2'b01, 32'h61, 32'h610, 0, 0, 1'b0, 2'b11, "rs2");
    chk_out(1'b0, 32'h60, 32'h600, 1'b0, 2'd1, "rs2");
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rs_async.ready", 32'(req_ready), 32'h0);
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, "rs_async");
    #1;
    rst = 1'b0;
    #1;
    chk("rs_rel.ready", 32'(req_ready), 32'h3);
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, "rs3");
    chk_out(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, "rs3");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
